// File: rtl/parking_pkg.sv
// parking_pkg: shared FSM state, default sizing and bay index type for the parking system
package parking_pkg;
  localparam int DEF_NUM_SPOTS = 8;
  localparam int DEF_GATE_CYCLES = 4;
  typedef enum logic {ST_IDLE, ST_GATE} state_t;
  typedef logic [$clog2(DEF_NUM_SPOTS)-1:0] spot_idx_t;
endpackage

// File: rtl/parking_lowest_free.sv
// parking_lowest_free: priority encoder returning the lowest free bay
// ports: occupancy (bit i = bay i taken), idx (lowest clear bit), any_free (some bit clear)
module parking_lowest_free #(
  parameter int N = 8,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] occupancy,
  output logic [W-1:0] idx,
  output logic         any_free
);
  // scanning downwards lets the lowest free index win
  always_comb begin
    idx = '0;
    any_free = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (!occupancy[i]) begin
        idx = W'(i);
        any_free = 1'b1;
      end
    end
  end
endmodule

// File: rtl/parking_spot_manager.sv
// parking_spot_manager: registered bay bitmap with entry handshake, timed gate window and exit checking
// ports: clk, rst_n (async low); enter_valid/enter_ready entry handshake; exit_valid/exit_idx exit request;
//        grant_valid/grant_idx allocation pulse; gate_open actuator; occupancy, free_count, full, empty status;
//        err_exit pulse for an exit naming a free or nonexistent bay
module parking_spot_manager
  import parking_pkg::*;
#(
  parameter int NUM_SPOTS = DEF_NUM_SPOTS,
  parameter int GATE_CYCLES = DEF_GATE_CYCLES,
  localparam int IDX_W = $clog2(NUM_SPOTS),
  localparam int CNT_W = $clog2(NUM_SPOTS + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enter_valid,
  output logic                 enter_ready,
  input  logic                 exit_valid,
  input  logic [IDX_W-1:0]     exit_idx,
  output logic                 grant_valid,
  output logic [IDX_W-1:0]     grant_idx,
  output logic                 gate_open,
  output logic [NUM_SPOTS-1:0] occupancy,
  output logic [CNT_W-1:0]     free_count,
  output logic                 full,
  output logic                 empty,
  output logic                 err_exit
);
  localparam int GC_W = $clog2(GATE_CYCLES + 1);
  localparam int PAD = 1 << IDX_W;
  state_t state, next_state;
  logic [GC_W-1:0] gate_cnt;
  logic [IDX_W-1:0] alloc_idx;
  logic any_free, accept, exit_ok;
  logic [PAD-1:0] occ_pad;
  logic [NUM_SPOTS-1:0] set_mask, clr_mask;
  parking_lowest_free #(.N(NUM_SPOTS), .W(IDX_W)) u_lowest_free (
    .occupancy(occupancy),
    .idx(alloc_idx),
    .any_free(any_free)
  );
  assign full = free_count == '0;
  assign empty = free_count == CNT_W'(NUM_SPOTS);
  assign accept = enter_valid && enter_ready;
  // padding with zeros makes an out-of-range exit_idx read as a free bay
  assign occ_pad = PAD'(occupancy);
  assign exit_ok = exit_valid && occ_pad[exit_idx];
  assign set_mask = {{(NUM_SPOTS-1){1'b0}}, accept} << alloc_idx;
  assign clr_mask = {{(NUM_SPOTS-1){1'b0}}, exit_ok} << exit_idx;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else state <= next_state;
  end
  always_comb begin
    next_state = (state == ST_IDLE) ? (accept ? ST_GATE : ST_IDLE)
                                    : ((gate_cnt == '0) ? ST_IDLE : ST_GATE);
  end
  always_comb begin
    enter_ready = (state == ST_IDLE) && !full;
    gate_open = state == ST_GATE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gate_cnt <= '0;
      occupancy <= '0;
      free_count <= CNT_W'(NUM_SPOTS);
      grant_valid <= 1'b0;
      grant_idx <= '0;
      err_exit <= 1'b0;
    end else begin
      gate_cnt <= accept ? GC_W'(GATE_CYCLES - 1)
                         : ((state == ST_GATE && gate_cnt != '0) ? gate_cnt - 1'b1 : gate_cnt);
      // set and clear bits are always distinct: allocation takes a free bay, a valid exit an occupied one
      occupancy <= (occupancy | set_mask) & ~clr_mask;
      free_count <= free_count - CNT_W'(accept) + CNT_W'(exit_ok);
      grant_valid <= accept;
      if (accept) grant_idx <= alloc_idx;
      err_exit <= exit_valid && !exit_ok;
    end
  end
  always @(posedge clk) begin
    if (rst_n) begin
      assert (!accept || (!full && any_free));
      assert (!exit_ok || !empty);
    end
  end
endmodule

// File: tb/tb_parking_spot_manager.sv
// tb_parking_spot_manager: directed self-checking bench with a grant scoreboard
module tb_parking_spot_manager;
  import parking_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic enter_valid = 1'b0;
  logic enter_ready;
  logic exit_valid = 1'b0;
  logic [2:0] exit_idx = '0;
  logic grant_valid;
  logic [2:0] grant_idx;
  logic gate_open;
  logic [7:0] occupancy;
  logic [3:0] free_count;
  logic full, empty, err_exit;
  int tests = 0;
  int fails = 0;
  spot_idx_t sb[$];
  parking_spot_manager #(.NUM_SPOTS(8), .GATE_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .enter_valid(enter_valid), .enter_ready(enter_ready),
    .exit_valid(exit_valid), .exit_idx(exit_idx),
    .grant_valid(grant_valid), .grant_idx(grant_idx),
    .gate_open(gate_open), .occupancy(occupancy),
    .free_count(free_count), .full(full), .empty(empty),
    .err_exit(err_exit)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  // grant scoreboard: every accepted entry pushes its expected bay, every grant pulse pops one
  always @(negedge clk) begin
    if (rst_n && grant_valid) begin
      if (sb.size() == 0) chk("sb_unexpected_grant", {61'd0, grant_idx}, 64'hdead);
      else chk("sb_grant_idx", {61'd0, grant_idx}, {61'd0, sb.pop_front()});
    end
  end
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    cyc();
    cyc();
    rst_n = 1'b1;
    cyc();
  endtask
  task automatic wait_ready();
    for (int n = 0; n < 20 && !enter_ready; n++) cyc();
    chk("ready_timeout", enter_ready, 1);
  endtask
  task automatic wait_gate();
    for (int n = 0; n < 20 && gate_open; n++) cyc();
    chk("gate_timeout", gate_open, 0);
  endtask
  task automatic enter(input int idx);
    sb.push_back(idx[2:0]);
    enter_valid = 1'b1;
    wait_ready();
    cyc();
    enter_valid = 1'b0;
  endtask
  task automatic do_exit(input int idx);
    exit_valid = 1'b1;
    exit_idx = idx[2:0];
    cyc();
    exit_valid = 1'b0;
  endtask
  initial begin
    int n;
    do_reset();
    chk("rst_occupancy", occupancy, 8'h00);
    chk("rst_free_count", free_count, 8);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_enter_ready", enter_ready, 1);
    chk("rst_gate_open", gate_open, 0);
    chk("rst_grant_valid", grant_valid, 0);
    chk("rst_grant_idx", grant_idx, 0);
    chk("rst_err_exit", err_exit, 0);
    enter(0);
    chk("e0_grant_valid", grant_valid, 1);
    chk("e0_occupancy", occupancy, 8'h01);
    chk("e0_free_count", free_count, 7);
    chk("e0_ready_low", enter_ready, 0);
    chk("e0_empty", empty, 0);
    n = gate_open ? 1 : 0;
    while (gate_open && n < 10) begin
      cyc();
      if (gate_open) n++;
    end
    chk("e0_gate_cycles", n, 4);
    chk("e0_grant_pulse", grant_valid, 0);
    chk("e0_ready_after", enter_ready, 1);
    do_exit(5);
    chk("ill_err_exit", err_exit, 1);
    chk("ill_occupancy", occupancy, 8'h01);
    chk("ill_free_count", free_count, 7);
    cyc();
    chk("ill_err_pulse", err_exit, 0);
    for (int i = 1; i < 8; i++) enter(i);
    chk("fill_occupancy", occupancy, 8'hFF);
    chk("fill_full", full, 1);
    chk("fill_free_count", free_count, 0);
    wait_gate();
    chk("fill_ready_low", enter_ready, 0);
    do_exit(3);
    chk("ex3_occupancy", occupancy, 8'hF7);
    chk("ex3_full", full, 0);
    chk("ex3_ready", enter_ready, 1);
    chk("ex3_err_exit", err_exit, 0);
    enter(3);
    chk("re3_occupancy", occupancy, 8'hFF);
    chk("re3_grant_idx", grant_idx, 3);
    wait_gate();
    do_reset();
    for (int i = 0; i < 4; i++) enter(i);
    wait_gate();
    do_exit(2);
    chk("pre_sim_occupancy", occupancy, 8'h0B);
    chk("pre_sim_free_count", free_count, 5);
    wait_ready();
    sb.push_back(3'd2);
    enter_valid = 1'b1;
    exit_valid = 1'b1;
    exit_idx = 3'd1;
    cyc();
    enter_valid = 1'b0;
    exit_valid = 1'b0;
    chk("sim_occupancy", occupancy, 8'h0D);
    chk("sim_grant_idx", grant_idx, 2);
    chk("sim_free_count", free_count, 5);
    chk("sim_err_exit", err_exit, 0);
    wait_gate();
    enter(1);
    chk("mid_gate_first", gate_open, 1);
    cyc();
    chk("mid_gate_second", gate_open, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_gate_open", gate_open, 0);
    chk("mid_rst_occupancy", occupancy, 8'h00);
    chk("mid_rst_free_count", free_count, 8);
    chk("mid_rst_grant_valid", grant_valid, 0);
    cyc();
    rst_n = 1'b1;
    cyc();
    chk("post_rst_ready", enter_ready, 1);
    chk("post_rst_gate_open", gate_open, 0);
    chk("post_rst_empty", empty, 1);
    chk("sb_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/parking_spot_manager.md
Name: parking_spot_manager

Overview:
Registered successor to the combinational capacity-bitmap update. It keeps the occupancy bitmap of NUM_SPOTS bays in state and serves entry requests through a valid/ready handshake. For each entry it allocates the lowest free bay and drives a timed gate-open window. Exits are processed by bay index, with error flagging, and the block publishes free count and full/empty status to the display and gate logic.

Parameters:
NUM_SPOTS, 8, number of parking bays; legal range 2..64.
GATE_CYCLES, 4, cycles gate_open stays high per granted entry; must be >= 1.
IDX_W, $clog2(NUM_SPOTS), width of bay index ports (derived; not overridden).
CNT_W, $clog2(NUM_SPOTS+1), width of free_count (derived; not overridden).

Ports:
clk  in  1  single system clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
enter_valid  in  1  car at entry requests a bay.
enter_ready  out  1  entry can be accepted this cycle.
exit_valid  in  1  car leaving bay exit_idx (single-cycle pulse per car).
exit_idx  in  IDX_W  bay being vacated.
grant_valid  out  1  one-cycle pulse: grant_idx is valid.
grant_idx  out  IDX_W  bay allocated to last accepted entry.
gate_open  out  1  entry gate actuator.
occupancy  out  NUM_SPOTS  bit i = 1 when bay i is occupied.
free_count  out  CNT_W  number of free bays.
full  out  1  free_count == 0.
empty  out  1  free_count == NUM_SPOTS.
err_exit  out  1  one-cycle pulse: illegal exit request.

Behaviour:
- Reset (async assert, sync deassert by the system): occupancy=0, free_count=NUM_SPOTS, full=0, empty=1, grant_valid=0, grant_idx=0, gate_open=0, err_exit=0, FSM=IDLE, gate counter=0. Reset mid-gate aborts the window immediately.
- All outputs are registered or decoded directly from registers; no combinational input-to-output paths.
- FSM states:
  - IDLE: enter_ready = !full.
  - GATE: enter_ready = 0, gate_open = 1.
- Accept condition: enter_valid && enter_ready, sampled at edge T. At T:
  - occupancy[lowest free index] <= 1.
  - grant_idx <= that index.
  - grant_valid = 1 for the cycle after T only.
  - FSM -> GATE; gate counter loads GATE_CYCLES-1.
- GATE state: gate_open = 1 for exactly GATE_CYCLES cycles starting the cycle after T. The counter decrements each cycle. At 0 the FSM returns to IDLE, so enter_ready can rise at the earliest GATE_CYCLES cycles after T+1.
- enter_valid while enter_ready = 0: no effect. The requester holds enter_valid; the block keeps no queue.
- Exit, in any FSM state:
  - If exit_idx < NUM_SPOTS and occupancy[exit_idx] = 1: clear the bit at the edge.
  - Otherwise (free bay or out-of-range index): occupancy unchanged, err_exit = 1 for the next cycle.
- Simultaneous entry accept and exit in the same cycle: both apply.
  - free_count is unchanged.
  - Allocation uses the pre-edge bitmap, so a bay vacated this cycle is not reallocated this cycle.
  - An exit naming the bay being allocated is necessarily to a free bay and is flagged as err_exit.
- full/enter_ready use the registered free_count. When full, an exit in cycle N makes enter_ready = 1 in cycle N+1 (IDLE state).
- free_count arithmetic: next = free_count - accept + valid_exit. It never wraps, because accept requires !full and a valid exit requires an occupied bay. The design carries assertions for both.
- Lowest-free search is a priority encode over ~occupancy; index 0 has highest priority.

Decomposition:
- Shared package parking_pkg: FSM state enum (ST_IDLE, ST_GATE), default NUM_SPOTS and GATE_CYCLES constants, and an index typedef usable across the parking system.
- One sub-module, parking_lowest_free: parametrised priority encoder. Inputs: occupancy. Outputs: idx and any_free.
- Counters, bitmap and FSM stay in the top module.

Test Plan:
All scenarios use NUM_SPOTS=8 and GATE_CYCLES=4.
- Reset: deassert rst_n -> occupancy=8'h00, free_count=8, empty=1, full=0, enter_ready=1, gate_open=0.
- Single entry: enter_valid held from empty -> grant_valid pulse with grant_idx=0; gate_open high exactly 4 cycles; occupancy=8'h01, free_count=7; enter_ready back to 1 after the window.
- Fill to full, then exit: 8 successive entries -> grant_idx 0..7 in order, occupancy=8'hFF, full=1, enter_ready=0. Then exit_idx=3 -> occupancy=8'hF7, full=0 the next cycle. The following entry is granted idx 3.
- Illegal exit: from occupancy=8'h01, exit_idx=5 -> err_exit one-cycle pulse, occupancy stays 8'h01, free_count stays 7.
- Simultaneous accept and exit: from occupancy=8'h0B, entry accepted in the same cycle as exit_idx=1 -> occupancy=8'h0D, grant_idx=2, free_count stays 5, no err_exit.
- Reset mid-gate: assert rst_n low during the 2nd gate_open cycle -> gate_open=0 immediately, occupancy=0, FSM=IDLE, enter_ready=1 after release.
